uart_tx_arbiter: RTL

Shares the single write port of one uart_fifo instance between NUM_REQ byte-stream requesters, such as the I2C response path and the status/error reporter.
- Grants are per packet: a requester holds the FIFO until it sends a beat with last=1, so UART frames are never interleaved.
- Round-robin fairness between packets.
- Back-pressures requesters on FIFO full.
- Releases a stalled lock after a programmable timeout.

---
 rtl/uart_tx_arbiter_pkg.sv | 19 +
 rtl/uart_tx_arbiter_rr_pick.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, uart_fifo
// status decode indices and counter sizing helper.
package uart_tx_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Bit positions inside the uart_fifo status word
    localparam int unsigned FIFO_STAT_FULL_BIT  = 0;
    localparam int unsigned FIFO_STAT_EMPTY_BIT = 1;

    // A disabled timeout (0) still needs a 1-bit counter to keep widths legal
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Circular priority encoder: returns the first set request after last_gnt_i,
// wrapping around, as a one-hot vector plus an any-request flag.
module rr_pick #(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_gnt_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic               any_o
);

    int unsigned     pos;
    logic [IDX_W-1:0] sel;
    logic            found;

    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        pos    = 0;
        sel    = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            pos = int'(last_gnt_i) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            sel = IDX_W'(pos);
            if (!found && req_i[sel]) begin
                pick_o[sel] = 1'b1;
                found       = 1'b1;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_fifo write port between
// NUM_REQ byte-stream requesters, with fifo-full back-pressure and lock timeout.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned LOCK_TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            timeout_err
);

    localparam int unsigned      IDX_W   = $clog2(NUM_REQ);
    localparam int unsigned      CNT_W   = cnt_width(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT);
    localparam bit               TMO_EN  = (LOCK_TIMEOUT != 0);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  tmo_q, tmo_d;

    logic [NUM_REQ-1:0]    pick;
    logic                  any_req;
    logic [IDX_W-1:0]      pick_idx;
    logic                  owner_valid;
    logic                  owner_last;
    logic                  beat;
    logic [DATA_WIDTH-1:0] owner_data;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_pick (
        .req_i      (req_valid),
        .last_gnt_i (last_gnt_q),
        .pick_o     (pick),
        .any_o      (any_req)
    );

    // Owner-side decode shared by the next-state and output logic
    always_comb begin
        pick_idx   = '0;
        owner_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
            end
            if (owner_q == IDX_W'(i)) begin
                owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        owner_valid = |(req_valid & grant_q);
        owner_last  = |(req_last & grant_q);
        beat        = (state_q == LOCKED) && owner_valid && !fifo_full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            last_gnt_q <= IDX_W'(NUM_REQ - 1);
            cnt_q      <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        tmo_d      = '0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = LOCKED;
                    grant_d = pick;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                if (beat) begin
                    cnt_d = '0;
                    if (owner_last) begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        last_gnt_d = owner_q;
                    end
                end else if (TMO_EN && !owner_valid && !fifo_full) begin
                    // A beat arriving at the limit is taken above, so only a
                    // still-idle owner is revoked here
                    if (cnt_q == CNT_MAX) begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        last_gnt_d = owner_q;
                        tmo_d      = grant_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        if (state_q == LOCKED) begin
            req_ready  = grant_q & {NUM_REQ{~fifo_full}};
            fifo_wr_en = beat;
            fifo_din   = owner_data;
        end
    end

    assign grant       = grant_q;
    assign timeout_err = tmo_q;

endmodule
